pixel_stream_loader: RTL and testbench
======================================

PIXEL_STREAM_LOADER -- requirements
Module: pixel_stream_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel width in bits, matching the fetcher data bus.
REQ-002 Parameter ARRAY_A_W, default 1: rows of the image matrix; only the value 1 is supported.
REQ-003 Parameter ARRAY_A_L, default 784: pixels per image, in row-major order.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port s_valid, input, 1 bit: the upstream pixel beat is valid.
REQ-007 Port s_data, input, DATA_WIDTH bits: signed pixel value.
REQ-008 Port s_last, input, 1 bit: marks the final pixel of an image.
REQ-009 Port s_ready, output, 1 bit: the loader accepts a beat this cycle.
REQ-010 Port comp_ready, input, 1 bit: the fetcher's ready output, high when a computation is done.
REQ-011 Port start_comp, output, 1 bit: one-cycle active-high pulse that launches the fetcher.
REQ-012 Port input_data, output, signed [DATA_WIDTH-1:0] [0:ARRAY_A_W-1][0:ARRAY_A_L-1]: image buffer, driven directly from registers.
REQ-013 Port frame_count, output, 8 bits: count of complete images accepted.
REQ-014 Port err_len, output, 1 bit: one-cycle pulse on a frame-length error.

Function
REQ-015 A beat SHALL be accepted exactly when s_valid and s_ready are both high in the same cycle.
REQ-016 The FSM SHALL have four states: LOAD, DROP, FULL and WAIT_DONE.
REQ-017 s_ready SHALL be high in LOAD and DROP, and low in FULL and WAIT_DONE; it is decoded combinationally from the state.
REQ-018 In LOAD, an accepted beat SHALL write s_data into input_data[0][cnt], where cnt is an index counter from 0 to ARRAY_A_L-1.
REQ-019 In LOAD, a beat accepted with cnt == ARRAY_A_L-1 and s_last == 1 SHALL do three things: clear cnt, increment frame_count (255 wraps to 0), and enter FULL.
REQ-020 In LOAD, a beat accepted with s_last == 1 and cnt < ARRAY_A_L-1 SHALL do three things: pulse err_len, clear cnt, and stay in LOAD (short frame discarded).
REQ-021 In LOAD, a beat accepted with cnt == ARRAY_A_L-1 and s_last == 0 SHALL do three things: pulse err_len, clear cnt, and enter DROP.
REQ-022 In DROP, accepted beats SHALL be discarded; an accepted beat with s_last == 1 SHALL return the FSM to LOAD.
REQ-023 In FULL, start_comp SHALL be high for exactly one cycle; the FSM then enters WAIT_DONE.
REQ-024 Timing of a good frame: final beat accepted in cycle N; start_comp high in cycle N+1; state is WAIT_DONE in cycle N+2.
REQ-025 In WAIT_DONE, a rising edge of comp_ready SHALL return the FSM to LOAD on the next clock.
REQ-026 The rising edge of comp_ready SHALL be detected as comp_ready high while a registered copy of comp_ready is low.
REQ-027 A comp_ready level that is already high on entry to WAIT_DONE SHALL NOT count as the completion edge.
REQ-028 input_data SHALL hold the full image unchanged from the start_comp cycle until the FSM leaves WAIT_DONE.
REQ-029 Bits of a discarded partial frame left in the buffer are don't-care; they are overwritten by the next frame.
REQ-030 err_len and start_comp SHALL never be high in the same cycle.

Reset
REQ-031 While reset_n is low, state SHALL be LOAD, cnt 0, and the comp_ready history register 0.
REQ-032 While reset_n is low, start_comp SHALL be 0, err_len 0, frame_count 0, and every input_data element 0.
REQ-033 While reset_n is low, s_ready SHALL be 0; it rises to 1 in the first cycle after reset release.
REQ-034 A reset asserted mid-frame or in WAIT_DONE SHALL abort the operation; no start_comp pulse is issued for the aborted frame.

Structure
REQ-035 Package sys_array_pkg SHALL hold the FSM state enum (loader_state_t) and the default constants DATA_WIDTH = 16 and ARRAY_A_L = 784.
REQ-036 The block SHALL be flat, with no sub-modules; the rising-edge detector is inline logic.
REQ-037 cnt SHALL be $clog2(ARRAY_A_L) bits wide.

Verification
REQ-038 Good frame: send 784 beats with s_data = index and s_last on the final beat. Required: input_data[0][k] == k; one start_comp pulse one cycle after the final beat; frame_count == 1; s_ready low.
REQ-039 Back-pressure: with the FSM in WAIT_DONE, hold s_valid high with s_data = 16'hFFFF. Required: no beat accepted and buffer unchanged; pulse comp_ready 0->1; s_ready is 1 on the following cycle.
REQ-040 Short frame: assert s_last on beat 100. Required: err_len pulses once, no start_comp, frame_count unchanged; a following good frame loads correctly.
REQ-041 Long frame: send 790 beats with s_last on beat 790. Required: err_len pulses at beat 784, beats 785-790 are dropped, no start_comp; the next good frame starts at index 0.
REQ-042 Stuck comp_ready: hold comp_ready high from before the final beat. Required: the FSM stays in WAIT_DONE until comp_ready falls and rises again.
REQ-043 Reset abort: assert reset_n low at beat 400, then release. Required: all outputs return to their reset values, no start_comp; s_ready is 1 one cycle after release.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types and default sizing for the systolic-array image loader.
package sys_array_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ARRAY_A_L  = 784;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    DROP      = 2'd1,
    FULL      = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/pixel_stream_loader.sv
// Collects one image from a valid/ready pixel stream into a register buffer,
// launches the fetcher and holds the image until the fetcher reports completion.
module pixel_stream_loader #(
  parameter int unsigned DATA_WIDTH = sys_array_pkg::DATA_WIDTH,
  parameter int unsigned ARRAY_A_W  = 1,
  parameter int unsigned ARRAY_A_L  = sys_array_pkg::ARRAY_A_L
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_valid,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  input  logic                         comp_ready,
  output logic                         start_comp,
  output logic signed [DATA_WIDTH-1:0] input_data [0:ARRAY_A_W-1][0:ARRAY_A_L-1],
  output logic [7:0]                   frame_count,
  output logic                         err_len
);

  import sys_array_pkg::*;

  localparam int unsigned     CNT_W    = $clog2(ARRAY_A_L);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARRAY_A_L - 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fc_q, fc_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic             comp_q, comp_d;
  logic             rdy_en_q, rdy_en_d;
  logic             accept;
  logic             wr_en;
  logic             comp_rise;

  // rdy_en_q keeps s_ready low while reset is held and for the release cycle.
  assign s_ready     = rdy_en_q && ((state_q == LOAD) || (state_q == DROP));
  assign accept      = s_valid && s_ready;
  assign comp_rise   = comp_ready && !comp_q;
  assign comp_d      = comp_ready;
  assign rdy_en_d    = 1'b1;
  assign start_comp  = start_q;
  assign err_len     = err_q;
  assign frame_count = fc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (s_last) begin
              fc_d    = fc_q + 8'd1;
              start_d = 1'b1;
              state_d = FULL;
            end else begin
              err_d   = 1'b1;
              state_d = DROP;
            end
          end else if (s_last) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DROP: begin
        if (accept && s_last) state_d = LOAD;
      end
      FULL: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // comp_q tracks comp_ready in every state, so a level already high
        // on entry never looks like a fresh completion edge.
        if (comp_rise) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      fc_q     <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      comp_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fc_q     <= fc_d;
      start_q  <= start_d;
      err_q    <= err_d;
      comp_q   <= comp_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // One register per pixel, written only by an accepted beat in LOAD.
  for (genvar i = 0; i < ARRAY_A_L; i++) begin : g_pix
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        input_data[0][i] <= '0;
      end else if (wr_en && (cnt_q == CNT_W'(i))) begin
        input_data[0][i] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_loader.sv
// Randomized scoreboard bench for pixel_stream_loader: frame-level model pushes
// expected start/error events, an independent monitor pops and checks them.
module tb_pixel_stream_loader;

  localparam int L  = 784;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 s_valid = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic                 s_last = 1'b0;
  logic                 s_ready;
  logic                 comp_ready = 1'b0;
  logic                 start_comp;
  logic signed [DW-1:0] input_data [0:0][0:L-1];
  logic [7:0]           frame_count;
  logic                 err_len;

  pixel_stream_loader #(.DATA_WIDTH(DW), .ARRAY_A_W(1), .ARRAY_A_L(L)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .comp_ready  (comp_ready),
    .start_comp  (start_comp),
    .input_data  (input_data),
    .frame_count (frame_count),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         ev_q[$];          // -1 = length error expected, else frame_count at start_comp
  logic [DW-1:0] exp_img [L];
  logic [7:0] fc_model = 8'd0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int img_mismatches();
    int n = 0;
    for (int i = 0; i < L; i++) if (input_data[0][i] !== exp_img[i]) n++;
    return n;
  endfunction

  function automatic int nonzero_pixels();
    int n = 0;
    for (int i = 0; i < L; i++) if (input_data[0][i] !== '0) n++;
    return n;
  endfunction

  // Monitor: consumes expected events whenever the DUT signals one.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (start_comp && err_len) check(1'b0 == (start_comp && err_len), "start_err_exclusive", 1, 0);
        if (start_comp) begin
          check(ev_q.size() != 0, "start_expected", ev_q.size(), 1);
          if (ev_q.size() != 0) begin
            e = ev_q.pop_front();
            check(e >= 0, "start_kind", e, 0);
            if (e >= 0) begin
              check(frame_count == 8'(e), "start_frame_count", frame_count, e);
              check(img_mismatches() == 0, "start_image", img_mismatches(), 0);
              check(s_ready == 1'b0, "start_ready_low", s_ready, 0);
            end
          end
        end
        if (err_len) begin
          check(ev_q.size() != 0, "err_expected", ev_q.size(), 1);
          if (ev_q.size() != 0) begin
            e = ev_q.pop_front();
            check(e < 0, "err_kind", e, -1);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input bit last, output bit ok);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    ok = s_ready;
    @(negedge clk);
  endtask

  // kind 0: data = index, kind 1: random. stop_at > 0 sends a truncated frame
  // with no expectation (used before a reset). stuck raises comp_ready early.
  task automatic send_frame(input int len, input int kind, input bit stuck, input int stop_at);
    logic [DW-1:0] dat [$];
    bit ok, all_ok;
    int n;
    all_ok = 1'b1;
    for (int k = 0; k < len; k++) dat.push_back(kind == 0 ? DW'(k) : DW'($urandom));
    if (stop_at == 0) begin
      if (len == L) begin
        fc_model = fc_model + 8'd1;
        for (int k = 0; k < L; k++) exp_img[k] = dat[k];
        ev_q.push_back(int'(fc_model));
      end else begin
        ev_q.push_back(-1);
      end
    end
    n = (stop_at > 0) ? stop_at : len;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if (stuck && k == len - 1) comp_ready = 1'b1;
      send_beat(dat[k], (stop_at == 0) && (k == len - 1), ok);
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check(all_ok, "frame_beats_accepted", all_ok, 1);
  endtask

  // After a good frame: back-pressure with 0xFFFF, then signal completion.
  task automatic finish_comp(input bit stuck);
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    s_last  = 1'b0;
    repeat (2 + $urandom_range(0, 4)) begin
      @(negedge clk);
      check(s_ready == 1'b0, "busy_ready_low", s_ready, 0);
    end
    if (stuck) begin
      comp_ready = 1'b0;
      @(negedge clk);
      check(s_ready == 1'b0, "stuck_still_busy", s_ready, 0);
    end
    comp_ready = 1'b1;
    @(negedge clk);
    check(s_ready == 1'b1, "ready_after_done", s_ready, 1);
    s_valid    = 1'b0;
    comp_ready = 1'b0;
    check(img_mismatches() == 0, "image_held", img_mismatches(), 0);
    check(frame_count == fc_model, "frame_count", frame_count, fc_model);
    check(ev_q.size() == 0, "events_drained", ev_q.size(), 0);
  endtask

  task automatic after_bad();
    repeat (3) @(negedge clk);
    check(ev_q.size() == 0, "err_seen", ev_q.size(), 0);
    check(frame_count == fc_model, "frame_count_kept", frame_count, fc_model);
    check(s_ready == 1'b1, "ready_after_bad", s_ready, 1);
  endtask

  task automatic check_reset_vals();
    check(s_ready == 1'b0, "rst_s_ready", s_ready, 0);
    check(start_comp == 1'b0, "rst_start_comp", start_comp, 0);
    check(err_len == 1'b0, "rst_err_len", err_len, 0);
    check(frame_count == 8'd0, "rst_frame_count", frame_count, 0);
    check(nonzero_pixels() == 0, "rst_buffer", nonzero_pixels(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    @(negedge clk);
    check(s_ready == 1'b1, "ready_after_release", s_ready, 1);

    send_frame(L, 0, 1'b0, 0);     // index pattern
    finish_comp(1'b0);
    send_frame(100, 1, 1'b0, 0);   // short frame
    after_bad();
    send_frame(L, 1, 1'b0, 0);
    finish_comp(1'b0);
    send_frame(790, 1, 1'b0, 0);   // long frame
    after_bad();
    send_frame(L, 0, 1'b0, 0);
    finish_comp(1'b0);
    send_frame(L, 1, 1'b1, 0);     // comp_ready stuck high
    finish_comp(1'b1);

    send_frame(L, 1, 1'b0, 400);   // abort mid-frame with reset
    reset_n = 1'b0;
    fc_model = 8'd0;
    @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    @(negedge clk);
    check(s_ready == 1'b1, "ready_after_abort", s_ready, 1);
    repeat (3) @(negedge clk);
    check(start_comp == 1'b0, "no_start_after_abort", start_comp, 0);
    send_frame(L, 1, 1'b0, 0);
    finish_comp(1'b0);

    for (int it = 0; it < 6; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6) begin
        send_frame(L, 1, kind == 0, 0);
        finish_comp(kind == 0);
      end else if (kind < 8) begin
        send_frame(int'($urandom_range(1, L - 1)), 1, 1'b0, 0);
        after_bad();
      end else begin
        send_frame(int'($urandom_range(L + 1, L + 12)), 1, 1'b0, 0);
        after_bad();
      end
    end

    repeat (5) @(negedge clk);
    check(ev_q.size() == 0, "final_queue_empty", ev_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
